// File: rtl/scan_doubler_if.sv
// scan_doubler_if: 15kHz pixel/sync input and 31kHz VGA output bundle for scan_doubler.
interface scan_doubler_if;
  logic in_clken, in_r, in_g, in_b, in_hs, in_vs;
  logic [3:0] vga_r, vga_g, vga_b;
  logic vga_hs_n, vga_vs_n;
  modport master(output in_clken, in_r, in_g, in_b, in_hs, in_vs,
                 input vga_r, vga_g, vga_b, vga_hs_n, vga_vs_n);
  modport slave(input in_clken, in_r, in_g, in_b, in_hs, in_vs,
                output vga_r, vga_g, vga_b, vga_hs_n, vga_vs_n);
endinterface

// File: rtl/scan_doubler.sv
// scan_doubler: 15kHz-to-31kHz line doubler using two 1024x3 line banks (ping-pong).
// Define SCAN_DOUBLER_SCANLINES_EN to dim the second repeat of each line to 4'h7.
module scan_doubler #(
  parameter int HS_WIDTH = 120
) (
  input logic clock32,
  input logic reset_n,
  scan_doubler_if.slave bus
);
  localparam logic [10:0] HS_W = 11'(HS_WIDTH);
  logic [2:0] mem [0:2047];
  logic hs_d, hs_rise, wbank, we, hs1, vs1;
  logic [10:0] wr_addr;
  logic [9:0] rd_addr, wa;
  logic [2:0] pix1;
  logic [3:0] lvl;
  assign hs_rise = bus.in_hs & ~hs_d;
  assign we = bus.in_clken & (hs_rise | ~wr_addr[10]);
  assign wa = hs_rise ? 10'd0 : wr_addr[9:0];
  // on hs_rise the sample lands in the bank that is about to become the write bank
  always_ff @(posedge clock32)
    if (we) mem[{wbank ^ hs_rise, wa}] <= {bus.in_r, bus.in_g, bus.in_b};
`ifdef SCAN_DOUBLER_SCANLINES_EN
  logic line_b, lb1;
  always_ff @(posedge clock32 or negedge reset_n)
    if (!reset_n) begin
      line_b <= 1'b0;
      lb1 <= 1'b0;
    end else begin
      line_b <= hs_rise ? 1'b0 : (rd_addr == 10'd1023 ? ~line_b : line_b);
      lb1 <= line_b;
    end
  assign lvl = lb1 ? 4'h7 : 4'hF;
`else
  assign lvl = 4'hF;
`endif
  always_ff @(posedge clock32 or negedge reset_n)
    if (!reset_n) begin
      hs_d <= 1'b0;
      wbank <= 1'b0;
      wr_addr <= '0;
      rd_addr <= '0;
      pix1 <= '0;
      hs1 <= 1'b0;
      vs1 <= 1'b0;
      bus.vga_r <= '0;
      bus.vga_g <= '0;
      bus.vga_b <= '0;
      bus.vga_hs_n <= 1'b1;
      bus.vga_vs_n <= 1'b1;
    end else begin
      hs_d <= bus.in_hs;
      wbank <= wbank ^ hs_rise;
      wr_addr <= hs_rise ? {10'd0, bus.in_clken} : wr_addr + {10'd0, we};
      rd_addr <= hs_rise ? 10'd0 : rd_addr + 10'd1;
      pix1 <= mem[{~wbank, rd_addr}];
      hs1 <= {1'b0, rd_addr} < HS_W;
      vs1 <= (rd_addr == 10'd0) ? bus.in_vs : vs1;
      bus.vga_hs_n <= ~hs1;
      bus.vga_vs_n <= ~vs1;
      bus.vga_r <= hs1 ? 4'h0 : {4{pix1[2]}} & lvl;
      bus.vga_g <= hs1 ? 4'h0 : {4{pix1[1]}} & lvl;
      bus.vga_b <= hs1 ? 4'h0 : {4{pix1[0]}} & lvl;
    end
endmodule

// File: tb/tb_scan_doubler.sv
// tb_scan_doubler: randomized line traffic against a line-buffer reference model, plus literal pins.
module tb_scan_doubler;
  localparam int HS = 120;
`ifdef SCAN_DOUBLER_SCANLINES_EN
  localparam logic [3:0] LB = 4'h7;
`else
  localparam logic [3:0] LB = 4'hF;
`endif
  typedef struct packed {
    bit hs_n, vs_n, known;
    bit [3:0] r, g, b;
  } exp_t;
  logic clock32 = 1'b0;
  logic reset_n = 1'b0;
  bit chk = 1'b0;
  int tests = 0, fails = 0, cyc = 0;
  scan_doubler_if bus();
  scan_doubler #(.HS_WIDTH(HS)) dut(.clock32(clock32), .reset_n(reset_n), .bus(bus.slave));
  always #5 clock32 = ~clock32;

  bit [2:0] bank [2][1024];
  bit bval [2][1024];
  int m_rd, m_wa;
  bit m_wb, m_lb, m_vs, m_hsd;
  exp_t stg, cur;

  function automatic exp_t rst_entry();
    exp_t e;
    e = '0;
    e.hs_n = 1'b1;
    e.vs_n = 1'b1;
    e.known = 1'b1;
    return e;
  endfunction

  // output after edge k reflects what the read pointer addressed before edge k-1
  initial begin
    stg = rst_entry();
    cur = rst_entry();
    forever begin
      @(posedge clock32 or negedge reset_n);
      if (!reset_n) begin
        m_rd = 0; m_wa = 0; m_wb = 0; m_lb = 0; m_vs = 0; m_hsd = 0;
        stg = rst_entry();
        cur = rst_entry();
      end else begin
        exp_t e;
        bit rise;
        bit [2:0] p;
        bit [3:0] l;
        rise = bus.in_hs && !m_hsd;
        m_hsd = bus.in_hs;
        if (m_rd == 0) m_vs = bus.in_vs;
        p = bank[!m_wb][m_rd];
        l = m_lb ? LB : 4'hF;
        e.hs_n = !(m_rd < HS);
        e.vs_n = !m_vs;
        e.known = bval[!m_wb][m_rd] || !e.hs_n;
        e.r = (e.hs_n && p[2]) ? l : 4'h0;
        e.g = (e.hs_n && p[1]) ? l : 4'h0;
        e.b = (e.hs_n && p[0]) ? l : 4'h0;
        cur = stg;
        stg = e;
        if (rise) begin
          m_wb = !m_wb; m_rd = 0; m_lb = 0; m_wa = 0;
        end else begin
          if (m_rd == 1023) m_lb = !m_lb;
          m_rd = (m_rd + 1) % 1024;
        end
        if (bus.in_clken && m_wa < 1024) begin
          bank[m_wb][m_wa] = {bus.in_r, bus.in_g, bus.in_b};
          bval[m_wb][m_wa] = 1'b1;
          m_wa++;
        end
      end
    end
  end

  initial forever begin
    @(negedge clock32);
    cyc++;
    if (chk) begin
      logic [11:0] col;
      bit ok;
      col = {bus.vga_r, bus.vga_g, bus.vga_b};
      ok = (bus.vga_hs_n === cur.hs_n) && (bus.vga_vs_n === cur.vs_n) &&
           (!cur.known || col === {cur.r, cur.g, cur.b}) && (cur.hs_n || col === 12'h0);
      tests++;
      if (!ok) begin
        fails++;
        $display("FAIL cycle %0d: hs_n/vs_n/rgb got %b/%b/%h want %b/%b/%h (known=%b)",
                 cyc, bus.vga_hs_n, bus.vga_vs_n, col, cur.hs_n, cur.vs_n,
                 {cur.r, cur.g, cur.b}, cur.known);
      end
    end
  end

  task automatic lit(input string nm, input logic [3:0] got, input logic [3:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic reset_lits(input string nm);
    lit({nm, "_hs_n"}, {3'b0, bus.vga_hs_n}, 4'h1);
    lit({nm, "_vs_n"}, {3'b0, bus.vga_vs_n}, 4'h1);
    lit({nm, "_rgb"}, bus.vga_r | bus.vga_g | bus.vga_b, 4'h0);
  endtask

  // mode: 0 random colour, 1 alternating red/blue, 2 white, 3 random colour on every cycle
  task automatic send_line(input int mode, input int nsamp, input int len, input bit coinc,
                           input bit lits, input int rst_at);
    int k, hlen;
    bit en, rel;
    bit [2:0] c;
    k = 0;
    rel = 0;
    hlen = 1 + $urandom_range(0, 7);
    bus.in_vs = 1'($urandom_range(0, 1));
    for (int i = 0; i < len; i++) begin
      @(negedge clock32);
      if (rel) begin
        reset_n = 1'b1;
        rel = 0;
      end
      bus.in_hs = i < hlen;
      en = (k < nsamp) && (mode == 3 || (coinc && i == 0) || (i % 2 == 1));
      c = 3'($urandom_range(0, 7));
      if (mode == 1) c = (k % 2 == 0) ? 3'b100 : 3'b001;
      if (mode == 2 || (coinc && k == 0)) c = 3'b111;
      {bus.in_r, bus.in_g, bus.in_b} = c;
      bus.in_clken = en;
      if (en) k++;
      if (lits) begin
        if (i == 3) lit("hs_start", {3'b0, bus.vga_hs_n}, 4'h0);
        if (i == 122) lit("hs_last", {3'b0, bus.vga_hs_n}, 4'h0);
        if (i == 123) lit("hs_end", {3'b0, bus.vga_hs_n}, 4'h1);
        if (i == 203) begin lit("px200_r", bus.vga_r, 4'hF); lit("px200_b", bus.vga_b, 4'h0); end
        if (i == 204) begin lit("px201_r", bus.vga_r, 4'h0); lit("px201_b", bus.vga_b, 4'hF); end
        if (i == 1227) lit("rep2_px200_r", bus.vga_r, LB);
        if (i == 1228) lit("rep2_px201_b", bus.vga_b, LB);
        if (i == 1126) lit("rep2_hs", {3'b0, bus.vga_hs_n}, 4'h0);
      end
      if (i == rst_at) begin
        #2 reset_n = 1'b0;
        #1 reset_lits("async_rst");
        rel = 1;
      end
    end
  endtask

  initial begin
    {bus.in_clken, bus.in_r, bus.in_g, bus.in_b, bus.in_hs, bus.in_vs} = '0;
    chk = 1'b1;
    repeat (3) @(negedge clock32);
    reset_lits("reset");
    reset_n = 1'b1;
    send_line(1, 1024, 2048, 0, 0, -1);
    send_line(2, 1024, 2048, 0, 1, -1);
    send_line(0, 1100, 2200, 0, 0, -1);
    send_line(3, 2048, 2048, 0, 0, -1);
    send_line(0, 1024, 2048, 1, 0, -1);
    send_line(0, 1024, 501, 0, 0, -1);
    send_line(2, 1024, 2048, 0, 0, 700);
    for (int n = 0; n < 4; n++)
      send_line($urandom_range(0, 3), 1024, $urandom_range(1500, 2500), 1'($urandom_range(0, 1)), 0, -1);
    send_line(2, 1024, 2048, 0, 0, -1);
    send_line(0, 1024, 2048, 0, 0, -1);
    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/scan_doubler.md
SCAN_DOUBLER -- requirements
Module: scan_doubler

Interface
REQ-001 The block SHALL have parameter HS_WIDTH, default 120, setting the output hsync pulse length in clock32 cycles (legal range 1..1023).
REQ-002 The block SHALL have port clock32, input, 1, the 32MHz system clock and its only clock.
REQ-003 The block SHALL have port reset_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port in_clken, input, 1, the input pixel-sample enable (nominally every 2nd cycle, 16MHz).
REQ-005 The block SHALL have ports in_r, in_g, in_b, input, 1 each, the 15kHz pixel colour from the BBC core.
REQ-006 The block SHALL have ports in_hs and in_vs, input, 1 each, the active-high 15kHz horizontal and vertical syncs.
REQ-007 The block SHALL have ports vga_r, vga_g, vga_b, output, 4 each, the 31kHz colour.
REQ-008 The block SHALL have ports vga_hs_n and vga_vs_n, output, 1 each, the active-low 31kHz syncs.

Function
REQ-009 The block SHALL contain two line banks of 1024 x 3 bits; the write bank is wbank and the read bank is !wbank.
REQ-010 The block SHALL detect an in_hs rising edge from a 1-cycle registered copy of in_hs, giving a 1-cycle hs_rise pulse.
REQ-011 On hs_rise the block SHALL toggle wbank, clear wr_addr to 0 and clear rd_addr to 0.
REQ-012 On in_clken with wr_addr < 1024, the block SHALL write {in_r,in_g,in_b} to wbank[wr_addr] and increment wr_addr (11-bit counter).
REQ-013 With wr_addr = 1024 the block SHALL suppress further writes until the next hs_rise.
REQ-014 If hs_rise and in_clken occur in the same cycle, the block SHALL write the sample to address 0 of the new bank and set wr_addr to 1.
REQ-015 rd_addr (10 bits) SHALL increment every cycle and wrap 1023->0, so each input line is output twice (two 1024-cycle lines); the line_b flag SHALL toggle on each wrap and clear on hs_rise.
REQ-016 With no hs_rise, rd_addr SHALL free-run and the block SHALL repeat the same read bank indefinitely.
REQ-017 Bank read SHALL be synchronous; the colour and hsync SHALL reach the output registers 2 cycles after the corresponding rd_addr value.
REQ-018 vga_hs_n SHALL be 0 for rd_addr in 0..HS_WIDTH-1 (delayed 2 cycles) and 1 otherwise.
REQ-019 The block SHALL force vga_r, vga_g and vga_b to 0 while vga_hs_n is 0.
REQ-020 Each colour bit SHALL map to 4'hF when 1 and 4'h0 when 0, except as modified by REQ-026.
REQ-021 The block SHALL sample in_vs on each rd_addr = 0 cycle, and vga_vs_n SHALL equal the inverse of that sample, aligned with vga_hs_n (2-cycle delay).

Reset
REQ-022 While reset_n = 0 the block SHALL hold vga_r/g/b = 0, vga_hs_n = 1 and vga_vs_n = 1.
REQ-023 While reset_n = 0 the block SHALL hold wbank, line_b, wr_addr, rd_addr and the delay pipeline at 0.
REQ-024 Bank contents SHALL NOT be cleared by reset; the output after a mid-frame reset is undefined until the first hs_rise, except that blanking per REQ-019 SHALL still apply.
REQ-025 An assertion of reset_n = 0 mid-line SHALL take effect asynchronously; operation SHALL restart from REQ-023 values on the first edge after release.

Configuration
REQ-026 With SCAN_DOUBLER_SCANLINES_EN defined, the block SHALL output an active colour as 4'h7 when line_b = 1 (the second repeat) and 4'hF when line_b = 0.
REQ-027 Without SCAN_DOUBLER_SCANLINES_EN defined, the block SHALL output active colour as 4'hF on both repeats, and line_b logic MAY be removed.

Verification
REQ-028 Scenario: reset_n = 0 during activity -> all outputs at REQ-022 values within the same cycle, with no clock edge required.
REQ-029 Scenario: write a 1024-sample line of alternating red/blue, then send hs_rise -> pixel n appears on vga_r/vga_b at rd_addr = n+2, twice, with vga_hs_n = 0 for 120 cycles at each line start.
REQ-030 Scenario: 1100 in_clken pulses within one line -> only addresses 0..1023 are written, and sample 1024 is not visible on the next output.
REQ-031 Scenario: hs_rise coincident with in_clken carrying white -> white at address 0 of the new bank, visible at the first pixel of the next output.
REQ-032 Scenario: hs_rise arriving at rd_addr = 500 -> rd_addr restarts at 0 and the hsync pulse restarts with no glitch shorter than HS_WIDTH.
REQ-033 Scenario: white line with SCAN_DOUBLER_SCANLINES_EN defined -> first repeat outputs 4'hF and second repeat 4'h7; without the macro, both repeats output 4'hF.
